// File: rtl/uart_cmd_parser.sv
// LF-terminated ASCII command parser: "S", "M<0-3>", "Thh:mm:ss".
// Lines are validated into shadow state and committed only on a clean LF.
module uart_cmd_parser #(
  parameter int TIMEOUT = 100_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic        o_req,
  output logic [1:0]  o_mode,
  output logic        o_mode_valid,
  output logic [23:0] o_time_bcd,
  output logic        o_time_valid,
  output logic        o_err,
  output logic        o_busy
);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, ARG_M, ARG_T, WAIT_LF, DISCARD} state_t;
  typedef enum logic [1:0] {CMD_S, CMD_M, CMD_T} cmd_t;

  state_t        state, state_n;
  cmd_t          cmd, cmd_n;
  logic [2:0]    idx, idx_n;
  logic [1:0]    shd_mode, shd_mode_n, mode_n;
  logic [23:0]   shd_time, shd_time_n, time_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          req_n, mode_vld_n, time_vld_n, err_n;
  logic [7:0]    dig;
  logic          is_lf, is_cr, ok;

  assign dig    = i_rx_data - 8'h30;
  assign is_lf  = (i_rx_data == 8'h0a);
  assign is_cr  = (i_rx_data == 8'h0d);
  assign o_busy = (state != IDLE);

  always_comb begin
    state_n    = state;
    cmd_n      = cmd;
    idx_n      = idx;
    shd_mode_n = shd_mode;
    shd_time_n = shd_time;
    mode_n     = o_mode;
    time_n     = o_time_bcd;
    req_n      = 1'b0;
    mode_vld_n = 1'b0;
    time_vld_n = 1'b0;
    err_n      = 1'b0;
    ok         = 1'b0;
    cnt_n      = (state == IDLE || i_rx_valid) ? '0 : cnt + 1'b1;

    if (i_rx_valid && !is_cr) begin
      case (state)
        IDLE: begin
          if (i_rx_data == "S")      begin state_n = WAIT_LF; cmd_n = CMD_S; end
          else if (i_rx_data == "M") state_n = ARG_M;
          else if (i_rx_data == "T") begin state_n = ARG_T; idx_n = 3'd0; end
          else if (!is_lf)           state_n = DISCARD;
        end
        ARG_M: begin
          if (dig <= 8'd3) begin
            shd_mode_n = dig[1:0];
            cmd_n      = CMD_M;
            state_n    = WAIT_LF;
          end else if (is_lf) begin
            state_n = IDLE;
            err_n   = 1'b1;
          end else state_n = DISCARD;
        end
        ARG_T: begin
          if (is_lf) begin
            state_n = IDLE;
            err_n   = 1'b1;
          end else begin
            // dig wraps high for bytes below '0', so one compare bounds both ends
            case (idx)
              3'd0:      ok = (dig <= 8'd2);
              3'd1:      ok = (dig <= ((shd_time[23:20] == 4'd2) ? 8'd3 : 8'd9));
              3'd2, 3'd5: ok = (i_rx_data == ":");
              3'd3, 3'd6: ok = (dig <= 8'd5);
              default:   ok = (dig <= 8'd9);
            endcase
            if (ok) begin
              case (idx)
                3'd0:    shd_time_n[23:20] = dig[3:0];
                3'd1:    shd_time_n[19:16] = dig[3:0];
                3'd3:    shd_time_n[15:12] = dig[3:0];
                3'd4:    shd_time_n[11:8]  = dig[3:0];
                3'd6:    shd_time_n[7:4]   = dig[3:0];
                3'd7:    shd_time_n[3:0]   = dig[3:0];
                default: ;
              endcase
              if (idx == 3'd7) begin
                state_n = WAIT_LF;
                cmd_n   = CMD_T;
              end else idx_n = idx + 3'd1;
            end else state_n = DISCARD;
          end
        end
        WAIT_LF: begin
          if (is_lf) begin
            state_n = IDLE;
            case (cmd)
              CMD_S:   req_n = 1'b1;
              CMD_M:   begin mode_n = shd_mode; mode_vld_n = 1'b1; end
              CMD_T:   begin time_n = shd_time; time_vld_n = 1'b1; end
              default: ;
            endcase
          end else state_n = DISCARD;
        end
        DISCARD: begin
          if (is_lf) begin
            state_n = IDLE;
            err_n   = 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end else if (!i_rx_valid && state != IDLE && cnt == TMAX) begin
      state_n = IDLE;
      err_n   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cmd          <= CMD_S;
      idx          <= '0;
      shd_mode     <= '0;
      shd_time     <= '0;
      cnt          <= '0;
      o_mode       <= '0;
      o_time_bcd   <= '0;
      o_req        <= 1'b0;
      o_mode_valid <= 1'b0;
      o_time_valid <= 1'b0;
      o_err        <= 1'b0;
    end else begin
      state        <= state_n;
      cmd          <= cmd_n;
      idx          <= idx_n;
      shd_mode     <= shd_mode_n;
      shd_time     <= shd_time_n;
      cnt          <= cnt_n;
      o_mode       <= mode_n;
      o_time_bcd   <= time_n;
      o_req        <= req_n;
      o_mode_valid <= mode_vld_n;
      o_time_valid <= time_vld_n;
      o_err        <= err_n;
    end
  end
endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
Receive-side counterpart of the ASCII sender. It consumes bytes from the UART RX path and parses LF-terminated ASCII command lines into control pulses for the watch/sensor core:
- send request,
- display-mode select,
- BCD time set.

Malformed lines, overlong lines and stalled lines are rejected with an error pulse. No partial update is ever applied.

Parameters:
TIMEOUT, 100_000_000, idle clock cycles allowed between bytes inside a line before the line is aborted (minimum 2).

Ports:
clk  in  1  system clock
rst_n  in  1  reset; one clock; reset is asynchronous and active-low
i_rx_data  in  8  received byte; valid only while i_rx_valid=1
i_rx_valid  in  1  one-cycle strobe; byte accepted on any clk edge where high
o_req  out  1  one-cycle pulse: "S" command accepted (drives sender i_start)
o_mode  out  2  last accepted mode; held between commands
o_mode_valid  out  1  one-cycle pulse: o_mode updated this cycle
o_time_bcd  out  24  last accepted time, {h10,h1,m10,m1,s10,s1}, 4 bits each; held
o_time_valid  out  1  one-cycle pulse: o_time_bcd updated this cycle
o_err  out  1  one-cycle pulse: line rejected (bad syntax/range/timeout)
o_busy  out  1  1 while a line is in progress (state != IDLE)

Behaviour:
- Reset: state IDLE, all pulses 0, o_mode=0, o_time_bcd=0, counters 0, o_busy=0.
- CR (8'h0d) is ignored in every state and does not count as a character. It does reset the timeout counter.
- States: IDLE, ARG_M, ARG_T, WAIT_LF, DISCARD.
- IDLE:
  - 'S' -> WAIT_LF with cmd=S.
  - 'M' -> ARG_M.
  - 'T' -> ARG_T with idx=0.
  - LF -> stay in IDLE; empty line, no pulse.
  - Any other byte -> DISCARD.
- ARG_M:
  - '0'..'3' -> latch into a shadow register, go to WAIT_LF with cmd=M.
  - LF -> IDLE with o_err.
  - Other -> DISCARD.
- ARG_T: idx counts 0..7, expected pattern "hh:mm:ss". Digits are checked on the fly; each accepted digit minus 8'h30 is written into the shadow time.
  - idx0: '0'..'2'.
  - idx1: '0'..'9', or '0'..'3' if h10=2.
  - idx2, idx5: ':'.
  - idx3, idx6: '0'..'5'.
  - idx4, idx7: '0'..'9'.
  - A valid char at idx7 -> WAIT_LF with cmd=T.
  - Invalid char -> DISCARD.
  - LF before idx7 is complete -> IDLE with o_err.
- WAIT_LF:
  - LF -> IDLE and commit the command:
    - S: o_req=1.
    - M: o_mode<=shadow, o_mode_valid=1.
    - T: o_time_bcd<=shadow, o_time_valid=1.
  - Any other byte -> DISCARD.
- DISCARD: swallow bytes until LF, then IDLE with o_err=1.
- Latency: every pulse and every held-output update is registered. It appears exactly one cycle after the LF byte is accepted and lasts one cycle. At most one of the four pulses is high in any cycle.
- Shadow registers never reach the outputs on a rejected line. o_mode and o_time_bcd change only together with their valid pulse.
- Timeout:
  - The counter clears on every accepted byte and in IDLE, and increments each cycle otherwise.
  - When it reaches TIMEOUT-1 in any non-IDLE state: next state IDLE, o_err pulse, shadow discarded.
  - A byte arriving in the same cycle as expiry wins: the byte is processed and the counter is cleared.
- Back-to-back bytes on consecutive cycles must be handled; there is no backpressure.
- rst_n low mid-line: immediate return to reset values; no pulse is emitted for the aborted line.

Test Plan:
- "S\n" at consecutive cycles -> o_req=1 for one cycle, the cycle after LF; no other pulse; o_busy 1 from cycle after 'S' until cycle after LF.
- "M2\r\n" -> o_mode=2 with o_mode_valid pulse after LF; then "M7\n" -> o_err pulse after LF, o_mode stays 2.
- "T23:59:58\n" -> o_time_bcd=24'h235958 plus o_time_valid; then "T24:00:00\n" -> o_err, o_time_bcd still 24'h235958.
- "T12:3\n" -> o_err after LF; "X\n" -> o_err; "\n" alone -> no pulse, o_busy stays 0; "S junk\n" -> single o_err only.
- TIMEOUT=16: send "T1" then idle 20 cycles -> o_err 16 cycles after the '1' byte, state IDLE; then "S\n" -> o_req normally.
- Send "T12:00" then pulse rst_n low -> all outputs at reset values, no o_err; then "M1\n" -> o_mode=1 with o_mode_valid.
